clic_claim_ctrl: RTL and testbench

// Consumer side of the CAN-style CLIC arbiter. Takes the combinational winner
// (valid/index/prio), applies a preemption threshold (current running level),
// and offers a registered interrupt request to the core.

---
 rtl/clic_claim_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_clic_claim_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clic_claim_ctrl.sv
// clic_claim_ctrl
// Consumer side of the CLIC arbiter. It filters the arbiter winner against the
// current running level, keeps a registered request towards the core, and
// turns the core's acknowledge into a one-cycle claim pulse. Preempted levels
// are kept on a small LIFO stack that unwinds on handler completion.

module clic_claim_ctrl #(
  parameter int PRIO_BITS  = 3,
  parameter int INDEX_BITS = 2,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arb_valid_i,
  input  logic [INDEX_BITS-1:0]        arb_index_i,
  input  logic [PRIO_BITS-1:0]         arb_prio_i,
  output logic                         irq_req_o,
  output logic [INDEX_BITS-1:0]        irq_id_o,
  output logic [PRIO_BITS-1:0]         irq_prio_o,
  input  logic                         irq_ack_i,
  input  logic                         irq_complete_i,
  output logic                         claim_valid_o,
  output logic [INDEX_BITS-1:0]        claim_index_o,
  output logic [PRIO_BITS-1:0]         level_o,
  output logic [$clog2(DEPTH+1)-1:0]   depth_o,
  output logic                         err_o
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_L = DW'(DEPTH);
  localparam logic [DW-1:0] ONE_L   = DW'(1);

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_e;

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   irqId_q, irqId_d;
  logic [PRIO_BITS-1:0]    irqPrio_q, irqPrio_d;
  logic                    claimValid_q, claimValid_d;
  logic [INDEX_BITS-1:0]   claimIndex_q, claimIndex_d;
  logic [PRIO_BITS-1:0]    level_q, level_d;
  logic [DW-1:0]           depth_q, depth_d;
  logic                    err_q, err_d;
  logic [PRIO_BITS-1:0]    stack_q [DEPTH];
  logic [PRIO_BITS-1:0]    stack_d [DEPTH];

  logic                    stackFull;
  logic                    stackEmpty;
  logic                    eligible;
  logic                    newCandidate;
  logic                    ackTaken;
  logic                    ackStray;
  logic                    doPush;
  logic                    doPop;
  logic                    completeErr;
  logic [PRIO_BITS-1:0]    popLevel;

  // Winner qualification: strictly above the running level and room to nest.
  always_comb begin
    stackFull    = (depth_q == DEPTH_L);
    stackEmpty   = (depth_q == '0);
    eligible     = arb_valid_i && (arb_prio_i > level_q) && !stackFull;
    newCandidate = (arb_prio_i > irqPrio_q) || (arb_index_i != irqId_q);
  end

  // Core-side event decode; an ack always wins over a same-cycle complete.
  always_comb begin
    ackTaken    = (state_q == ST_REQ) && irq_ack_i;
    ackStray    = (state_q == ST_IDLE) && irq_ack_i;
    doPush      = ackTaken && !stackFull;
    doPop       = irq_complete_i && !irq_ack_i && !stackEmpty;
    completeErr = irq_complete_i && (irq_ack_i || stackEmpty);
    err_d       = ackStray || completeErr;
  end

  // Request FSM: offer, upgrade, withdraw or hand over to the core.
  always_comb begin
    state_d      = state_q;
    irqId_d      = irqId_q;
    irqPrio_d    = irqPrio_q;
    claimValid_d = 1'b0;
    claimIndex_d = claimIndex_q;
    case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          state_d   = ST_REQ;
          irqId_d   = arb_index_i;
          irqPrio_d = arb_prio_i;
        end
      end
      ST_REQ: begin
        if (irq_ack_i) begin
          state_d      = ST_IDLE;
          claimValid_d = 1'b1;
          claimIndex_d = irqId_q;
        end else if (!eligible) begin
          state_d = ST_IDLE;
        end else if (newCandidate) begin
          irqId_d   = arb_index_i;
          irqPrio_d = arb_prio_i;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read the top of the nesting stack (entry depth-1).
  always_comb begin
    popLevel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i + 1) == depth_q) begin
        popLevel = stack_q[i];
      end
    end
  end

  // Running level and nesting depth: push on ack, pop on completion.
  always_comb begin
    level_d = level_q;
    depth_d = depth_q;
    if (doPush) begin
      level_d = irqPrio_q;
      depth_d = depth_q + ONE_L;
    end else if (doPop) begin
      level_d = popLevel;
      depth_d = depth_q - ONE_L;
    end
  end

  // Stack write: the preempted level goes into the slot at the current depth.
  always_comb begin
    stack_d = stack_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (doPush && (DW'(i) == depth_q)) begin
        stack_d[i] = level_q;
      end
    end
  end

  // Control and output registers; reset drops any request or pending claim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      irqId_q      <= '0;
      irqPrio_q    <= '0;
      claimValid_q <= 1'b0;
      claimIndex_q <= '0;
      level_q      <= '0;
      depth_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      irqId_q      <= irqId_d;
      irqPrio_q    <= irqPrio_d;
      claimValid_q <= claimValid_d;
      claimIndex_q <= claimIndex_d;
      level_q      <= level_d;
      depth_q      <= depth_d;
      err_q        <= err_d;
    end
  end

  // Nesting stack storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign irq_req_o     = (state_q == ST_REQ);
  assign irq_id_o      = irqId_q;
  assign irq_prio_o    = irqPrio_q;
  assign claim_valid_o = claimValid_q;
  assign claim_index_o = claimIndex_q;
  assign level_o       = level_q;
  assign depth_o       = depth_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_clic_claim_ctrl.sv
// tb_clic_claim_ctrl
// Directed scenario tasks followed by a randomized run checked against a
// queue-based behavioural model of the claim controller.

module tb_clic_claim_ctrl;

  localparam int PB    = 3;
  localparam int IB    = 2;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arb_valid;
  logic [IB-1:0] arb_index;
  logic [PB-1:0] arb_prio;
  logic          irq_req;
  logic [IB-1:0] irq_id;
  logic [PB-1:0] irq_prio;
  logic          irq_ack;
  logic          irq_complete;
  logic          claim_valid;
  logic [IB-1:0] claim_index;
  logic [PB-1:0] level;
  logic [DW-1:0] depth;
  logic          err;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit mReq;
  int mId, mPrio, mLvl;
  int mStk[$];
  bit eClaim, eErr;
  int eClaimIdx;

  clic_claim_ctrl #(.PRIO_BITS(PB), .INDEX_BITS(IB), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arb_valid_i    (arb_valid),
    .arb_index_i    (arb_index),
    .arb_prio_i     (arb_prio),
    .irq_req_o      (irq_req),
    .irq_id_o       (irq_id),
    .irq_prio_o     (irq_prio),
    .irq_ack_i      (irq_ack),
    .irq_complete_i (irq_complete),
    .claim_valid_o  (claim_valid),
    .claim_index_o  (claim_index),
    .level_o        (level),
    .depth_o        (depth),
    .err_o          (err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int idx, input int p, input logic a, input logic c);
    arb_valid    = v;
    arb_index    = IB'(idx);
    arb_prio     = PB'(p);
    irq_ack      = a;
    irq_complete = c;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  // Reference: one cycle of the controller rules, expressed on a level stack
  task automatic model_step(input bit v, input int idx, input int p, input bit a, input bit c);
    bit elig;
    elig   = v && (p > mLvl) && (mStk.size() < DEPTH);
    eErr   = (a && !mReq) || (c && a) || (c && !a && mStk.size() == 0);
    eClaim = 0;
    if (mReq) begin
      if (a) begin
        eClaim    = 1;
        eClaimIdx = mId;
        mStk.push_back(mLvl);
        mLvl = mPrio;
        mReq = 0;
      end else if (!elig) begin
        mReq = 0;
      end else if (p > mPrio || idx != mId) begin
        mId   = idx;
        mPrio = p;
      end
    end else if (elig) begin
      mReq  = 1;
      mId   = idx;
      mPrio = p;
    end
    if (c && !a && mStk.size() > 0) mLvl = mStk.pop_back();
  endtask

  task automatic test_reset();
    drive(1, 2, 5, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if ({irq_req, irq_id, irq_prio, claim_valid, claim_index, level, depth, err} !== '0) begin failures++; $display("[TB] FAIL reset_outputs got=%h exp=0", {irq_req, irq_id, irq_prio, claim_valid, claim_index, level, depth, err}); end
    rst_n = 1'b1;
    tick();
    checks++; if (irq_req !== 1'b1) begin failures++; $display("[TB] FAIL first_req got=%0b exp=1", irq_req); end
    checks++; if (irq_id !== 2'd2) begin failures++; $display("[TB] FAIL first_id got=%0d exp=2", irq_id); end
    checks++; if (irq_prio !== 3'd5) begin failures++; $display("[TB] FAIL first_prio got=%0d exp=5", irq_prio); end
    checks++; if (claim_valid !== 1'b0) begin failures++; $display("[TB] FAIL first_noclaim got=%0b exp=0", claim_valid); end
  endtask

  task automatic test_basic_ack();
    drive(1, 2, 5, 1, 0);
    tick();
    checks++; if (claim_valid !== 1'b1) begin failures++; $display("[TB] FAIL ack_claim got=%0b exp=1", claim_valid); end
    checks++; if (claim_index !== 2'd2) begin failures++; $display("[TB] FAIL ack_claim_idx got=%0d exp=2", claim_index); end
    checks++; if (level !== 3'd5) begin failures++; $display("[TB] FAIL ack_level got=%0d exp=5", level); end
    checks++; if (depth !== 3'd1) begin failures++; $display("[TB] FAIL ack_depth got=%0d exp=1", depth); end
    checks++; if (irq_req !== 1'b0) begin failures++; $display("[TB] FAIL ack_req_drop got=%0b exp=0", irq_req); end
    drive(1, 2, 5, 0, 0);
    tick();
    checks++; if (claim_valid !== 1'b0) begin failures++; $display("[TB] FAIL claim_one_cycle got=%0b exp=0", claim_valid); end
    checks++; if (irq_req !== 1'b0) begin failures++; $display("[TB] FAIL no_rereq got=%0b exp=0", irq_req); end
    drive(1, 1, 3, 0, 0);
    tick();
    tick();
    checks++; if (irq_req !== 1'b0) begin failures++; $display("[TB] FAIL low_prio_blocked got=%0b exp=0", irq_req); end
    checks++; if (level !== 3'd5) begin failures++; $display("[TB] FAIL level_held got=%0d exp=5", level); end
  endtask

  task automatic test_nesting();
    drive(1, 3, 7, 0, 0);
    tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 2'd3 || irq_prio !== 3'd7) begin failures++; $display("[TB] FAIL nest_req got=%0b/%0d/%0d exp=1/3/7", irq_req, irq_id, irq_prio); end
    drive(1, 3, 7, 1, 0);
    tick();
    checks++; if (claim_valid !== 1'b1 || claim_index !== 2'd3) begin failures++; $display("[TB] FAIL nest_claim got=%0b/%0d exp=1/3", claim_valid, claim_index); end
    checks++; if (level !== 3'd7 || depth !== 3'd2) begin failures++; $display("[TB] FAIL nest_push got=%0d/%0d exp=7/2", level, depth); end
    drive(0, 0, 0, 0, 1);
    tick();
    checks++; if (level !== 3'd5 || depth !== 3'd1) begin failures++; $display("[TB] FAIL nest_pop1 got=%0d/%0d exp=5/1", level, depth); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL nest_pop_err got=%0b exp=0", err); end
    tick();
    checks++; if (level !== 3'd0 || depth !== 3'd0) begin failures++; $display("[TB] FAIL nest_pop2 got=%0d/%0d exp=0/0", level, depth); end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_upgrade_withdraw();
    apply_reset();
    drive(1, 1, 2, 0, 0);
    tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 2'd1 || irq_prio !== 3'd2) begin failures++; $display("[TB] FAIL upg_initial got=%0b/%0d/%0d exp=1/1/2", irq_req, irq_id, irq_prio); end
    drive(1, 3, 6, 0, 0);
    tick();
    checks++; if (irq_req !== 1'b1 || irq_id !== 2'd3 || irq_prio !== 3'd6) begin failures++; $display("[TB] FAIL upg_switch got=%0b/%0d/%0d exp=1/3/6", irq_req, irq_id, irq_prio); end
    drive(0, 3, 6, 0, 0);
    tick();
    checks++; if (irq_req !== 1'b0 || claim_valid !== 1'b0) begin failures++; $display("[TB] FAIL withdraw got=%0b/%0b exp=0/0", irq_req, claim_valid); end
    tick();
    checks++; if (claim_valid !== 1'b0 || depth !== 3'd0) begin failures++; $display("[TB] FAIL withdraw_noclaim got=%0b/%0d exp=0/0", claim_valid, depth); end
  endtask

  task automatic test_full_stack();
    apply_reset();
    for (int p = 1; p <= 4; p++) begin
      drive(1, p % 4, p, 0, 0);
      tick();
      checks++; if (irq_req !== 1'b1 || irq_prio !== PB'(p)) begin failures++; $display("[TB] FAIL fill_req%0d got=%0b/%0d exp=1/%0d", p, irq_req, irq_prio, p); end
      drive(1, p % 4, p, 1, 0);
      tick();
      checks++; if (level !== PB'(p) || depth !== DW'(p) || claim_valid !== 1'b1) begin failures++; $display("[TB] FAIL fill_push%0d got=%0d/%0d/%0b exp=%0d/%0d/1", p, level, depth, claim_valid, p, p); end
    end
    drive(1, 0, 7, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (irq_req !== 1'b0 || depth !== 3'd4) begin failures++; $display("[TB] FAIL full_blocks%0d got=%0b/%0d exp=0/4", k, irq_req, depth); end
    end
    drive(0, 0, 0, 0, 1);
    for (int k = 3; k >= 0; k--) begin
      tick();
      checks++; if (level !== PB'(k) || depth !== DW'(k)) begin failures++; $display("[TB] FAIL unwind%0d got=%0d/%0d exp=%0d/%0d", k, level, depth, k, k); end
    end
    tick();
    checks++; if (err !== 1'b1 || level !== 3'd0 || depth !== 3'd0) begin failures++; $display("[TB] FAIL empty_complete got=%0b/%0d/%0d exp=1/0/0", err, level, depth); end
    drive(0, 0, 0, 0, 0);
    tick();
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL err_pulse got=%0b exp=0", err); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(1, 2, 5, 0, 0);
    tick();
    checks++; if (irq_req !== 1'b1) begin failures++; $display("[TB] FAIL arst_pre_req got=%0b exp=1", irq_req); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({irq_req, irq_id, irq_prio, claim_valid, level, depth, err} !== '0) begin failures++; $display("[TB] FAIL arst_req got=%h exp=0", {irq_req, irq_id, irq_prio, claim_valid, level, depth, err}); end
    tick();
    rst_n = 1'b1;
    tick();
    drive(1, 2, 5, 1, 0);
    tick();
    checks++; if (claim_valid !== 1'b1) begin failures++; $display("[TB] FAIL arst_pre_claim got=%0b exp=1", claim_valid); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({irq_req, claim_valid, claim_index, level, depth, err} !== '0) begin failures++; $display("[TB] FAIL arst_claim got=%h exp=0", {irq_req, claim_valid, claim_index, level, depth, err}); end
    drive(0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (claim_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("[TB] FAIL arst_after got=%0b/%0d exp=0/0", claim_valid, level); end
  endtask

  task automatic test_ack_complete();
    apply_reset();
    drive(1, 1, 3, 0, 0);
    tick();
    checks++; if (irq_req !== 1'b1) begin failures++; $display("[TB] FAIL ac_req got=%0b exp=1", irq_req); end
    drive(1, 1, 3, 1, 1);
    tick();
    checks++; if (claim_valid !== 1'b1 || claim_index !== 2'd1) begin failures++; $display("[TB] FAIL ac_claim got=%0b/%0d exp=1/1", claim_valid, claim_index); end
    checks++; if (level !== 3'd3 || depth !== 3'd1 || err !== 1'b1) begin failures++; $display("[TB] FAIL ac_push_err got=%0d/%0d/%0b exp=3/1/1", level, depth, err); end
    drive(0, 0, 0, 0, 0);
    tick();
    checks++; if (err !== 1'b0 || depth !== 3'd1 || level !== 3'd3) begin failures++; $display("[TB] FAIL ac_after got=%0b/%0d/%0d exp=0/1/3", err, depth, level); end
    drive(0, 0, 0, 1, 0);
    tick();
    checks++; if (err !== 1'b1 || claim_valid !== 1'b0 || depth !== 3'd1) begin failures++; $display("[TB] FAIL stray_ack got=%0b/%0b/%0d exp=1/0/1", err, claim_valid, depth); end
    drive(0, 0, 0, 0, 0);
    tick();
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL stray_ack_pulse got=%0b exp=0", err); end
  endtask

  task automatic test_random();
    int rv, ridx, rp, ra, rc;
    apply_reset();
    mReq = 0; mId = 0; mPrio = 0; mLvl = 0; mStk.delete();
    rv = 0; ridx = 0; rp = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        rv   = ($urandom_range(0, 9) < 7) ? 1 : 0;
        ridx = $urandom_range(0, 3);
        rp   = $urandom_range(0, 7);
      end
      ra = mReq ? (($urandom_range(0, 9) < 4) ? 1 : 0) : (($urandom_range(0, 19) == 0) ? 1 : 0);
      rc = ($urandom_range(0, 9) < 2) ? 1 : 0;
      drive(rv[0], ridx, rp, ra[0], rc[0]);
      model_step(rv[0], ridx, rp, ra[0], rc[0]);
      tick();
      checks++; if (irq_req !== mReq) begin failures++; $display("[TB] FAIL rnd_req cyc=%0d got=%0b exp=%0b", n, irq_req, mReq); end
      checks++; if (level !== PB'(mLvl)) begin failures++; $display("[TB] FAIL rnd_level cyc=%0d got=%0d exp=%0d", n, level, mLvl); end
      checks++; if (depth !== DW'(mStk.size())) begin failures++; $display("[TB] FAIL rnd_depth cyc=%0d got=%0d exp=%0d", n, depth, mStk.size()); end
      checks++; if (claim_valid !== eClaim) begin failures++; $display("[TB] FAIL rnd_claim cyc=%0d got=%0b exp=%0b", n, claim_valid, eClaim); end
      checks++; if (err !== eErr) begin failures++; $display("[TB] FAIL rnd_err cyc=%0d got=%0b exp=%0b", n, err, eErr); end
      if (mReq) begin
        checks++; if (irq_id !== IB'(mId) || irq_prio !== PB'(mPrio)) begin failures++; $display("[TB] FAIL rnd_idprio cyc=%0d got=%0d/%0d exp=%0d/%0d", n, irq_id, irq_prio, mId, mPrio); end
      end
      if (eClaim) begin
        checks++; if (claim_index !== IB'(eClaimIdx)) begin failures++; $display("[TB] FAIL rnd_claim_idx cyc=%0d got=%0d exp=%0d", n, claim_index, eClaimIdx); end
      end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_basic_ack();
    test_nesting();
    test_upgrade_withdraw();
    test_full_stack();
    test_async_reset();
    test_ack_complete();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Runaway guard
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
